div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/calc_pkg.sv | 13 +
 rtl/subtractor.sv | 12 +
 rtl/div_sequencer.sv | 133 +++++++++++++
 tb/tb_div_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared width constant and divider state encoding
package calc_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/subtractor.sv
// rtl/subtractor.sv - zero-extended subtractor, bit DATA_W of diff is the borrow
module subtractor
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   diff
);

    assign diff = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - repeated-subtraction divider; DIV_SIGNED_EN enables two's complement operands
module div_sequencer
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero,
    output logic              overflow
);

    div_state_t        state, state_nxt;
    logic [DATA_W-1:0] rem_w, quo_w, dvs_w;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W-1:0] fix_q, fix_r;
    logic [DATA_W:0]   diff;
    logic              borrow;
    logic              dz_w;

    subtractor u_sub (
        .a    (rem_w),
        .b    (dvs_w),
        .diff (diff)
    );

    assign borrow = diff[DATA_W];

`ifdef DIV_SIGNED_EN
    logic sa_w, sb_w;
    logic fix_ovf;
    logic ovf_r;

    // -128 has no positive twin; as an unsigned magnitude it is simply 8'h80
    assign mag_a = dividend[DATA_W-1] ? -dividend : dividend;
    assign mag_b = divisor[DATA_W-1]  ? -divisor  : divisor;

    always_comb begin
        fix_q   = (sa_w ^ sb_w) ? -quo_w : quo_w;
        fix_r   = sa_w ? -rem_w : rem_w;
        fix_ovf = !(sa_w ^ sb_w) && quo_w[DATA_W-1];
        if (dz_w) begin
            fix_q   = '1;
            fix_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_w  <= 1'b0;
            sb_w  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && start) begin
            sa_w  <= dividend[DATA_W-1];
            sb_w  <= divisor[DATA_W-1];
        end else if (state == FIX) begin
            ovf_r <= fix_ovf;
        end
    end

    assign overflow = ovf_r;
`else
    assign mag_a    = dividend;
    assign mag_b    = divisor;
    assign fix_q    = dz_w ? '1 : quo_w;
    assign fix_r    = rem_w;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero divisor skips the loop; FIX still publishes the results one edge later
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? FIX : LOOP;
            LOOP:    if (borrow) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_w     <= '0;
            quo_w     <= '0;
            dvs_w     <= '0;
            dz_w      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_w <= mag_a;
                        quo_w <= '0;
                        dvs_w <= mag_b;
                        dz_w  <= (divisor == '0);
                    end
                end
                LOOP: begin
                    if (!borrow) begin
                        rem_w <= diff[DATA_W-1:0];
                        quo_w <= quo_w + 1'b1;
                    end
                end
                FIX: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    div_zero  <= dz_w;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - table-driven bench for div_sequencer plus multi-cycle corner sequences
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one operation, then wait for done; inj>0 pulses a stray start sampled at that edge
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int inj,
                          output int lat, output int busy_cnt, output bit moved);
        logic [7:0] q0, r0;
        logic       z0, o0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        q0 = quotient; r0 = remainder; z0 = div_zero; o0 = overflow;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        moved    = 1'b0;
        while (!done && lat < 400) begin
            if (busy) busy_cnt++;
            if (quotient !== q0 || remainder !== r0 || div_zero !== z0 || overflow !== o0)
                moved = 1'b1;
            @(posedge clk); #1;
            lat++;
            start = (inj > 0 && lat == inj - 1);
            if (start) begin
                dividend = 8'd3;
                divisor  = 8'd3;
            end
        end
        start = 1'b0;
    endtask

    // Holds start through the DONE cycle; it must not be accepted
    task automatic after_done(input string tag, input logic [7:0] q);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_width"}, done, 1'b0);
        chk({tag, "_start_in_done"}, busy, 1'b0);
        chk({tag, "_q_held"}, quotient, q);
    endtask

    initial begin
        int  lat, bcnt, seen;
        bit  moved;
        string tag;

        vecs.push_back(vec_t'{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 16});
        vecs.push_back(vec_t'{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1'b0, 1});
        vecs.push_back(vec_t'{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{8'd7,   8'd100, 8'd0,   8'd7,   1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1'b0, 1});
`ifdef DIV_SIGNED_EN
        vecs.push_back(vec_t'{8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0, 1'b0, 16});
        vecs.push_back(vec_t'{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1, 130});
        vecs.push_back(vec_t'{8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0, 5});
        vecs.push_back(vec_t'{8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0, 5});
        vecs.push_back(vec_t'{8'hFB,  8'h00,  8'hFF,  8'hFB,  1'b1, 1'b0, 1});
        vecs.push_back(vec_t'{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0, 130});
`else
        vecs.push_back(vec_t'{8'd200, 8'd200, 8'd1,   8'd0,   1'b0, 1'b0, 3});
        vecs.push_back(vec_t'{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b0, 17});
        vecs.push_back(vec_t'{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 1'b0, 44});
`endif
        vecs.push_back(vec_t'{8'd1,   8'd1,   8'd1,   8'd0,   1'b0, 1'b0, 3});

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 8'h00);
        chk("rst_r", remainder, 8'h00);
        chk("rst_dz", div_zero, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d_%0h_%0h", i, vecs[i].a, vecs[i].b);
            do_div(vecs[i].a, vecs[i].b, 0, lat, bcnt, moved);
            chk({tag, "_latency"}, lat, vecs[i].lat);
            chk({tag, "_busy_cycles"}, bcnt, vecs[i].lat);
            chk({tag, "_held_while_busy"}, moved, 1'b0);
            chk({tag, "_q"}, quotient, vecs[i].q);
            chk({tag, "_r"}, remainder, vecs[i].r);
            chk({tag, "_dz"}, div_zero, vecs[i].dz);
            chk({tag, "_ovf"}, overflow, vecs[i].ovf);
            after_done(tag, vecs[i].q);
        end

`ifndef DIV_SIGNED_EN
        do_div(8'd255, 8'd1, 100, lat, bcnt, moved);
        chk("max_latency", lat, 257);
        chk("max_q", quotient, 8'd255);
        chk("max_r", remainder, 8'd0);
        chk("max_busy_cycles", bcnt, 257);
        after_done("max", 8'd255);
`endif

        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_q", quotient, 8'h00);
        chk("abort_r", remainder, 8'h00);
        chk("abort_dz", div_zero, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);

        do_div(8'd9, 8'd4, 0, lat, bcnt, moved);
        chk("fresh_latency", lat, 4);
        chk("fresh_q", quotient, 8'd2);
        chk("fresh_r", remainder, 8'd1);
        chk("fresh_dz", div_zero, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
